// File: rtl/io_pkg.sv
// Shared definitions for the io_sched register-file write-port scheduler.
package io_pkg;
  localparam int NPORT = 4;
  localparam int PW    = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CAPT  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CAPT  = ST_CAPT,
    WRITE = ST_WRITE,
    ACK   = ST_ACK,
    DROP  = ST_DROP
  } state_t;
endpackage

// File: rtl/io_sched_if.sv
// Port-side request/data and register-file write bus for io_sched.
interface io_sched_if #(parameter int WIDTH = 8);
  import io_pkg::*;

  logic [NPORT-1:0]            req;
  logic [NPORT-1:0][WIDTH-1:0] din;
  logic                        cpu_we;
  logic [PW-1:0]               sel;
  logic                        we;
  logic [3:0]                  wa;
  logic [WIDTH-1:0]            wd;
  logic [NPORT-1:0]            ack;
  logic                        busy;

  modport slave  (input  req, din, cpu_we, output sel, we, wa, wd, ack, busy);
  modport master (output req, din, cpu_we, input  sel, we, wa, wd, ack, busy);
endinterface

// File: rtl/io_sched_rr_pick.sv
// Combinational 4-way round-robin picker; IO_SCHED_PRIO0_EN gives port 0 absolute priority.
module rr_pick
  import io_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             valid,
  output logic [PW-1:0]    idx
);
  always_comb begin
    logic [PW-1:0] i;
    valid = 1'b0;
    idx   = '0;
    i     = '0;
    // Scan downward so the last hit, i.e. the one closest to ptr, wins.
    for (int k = NPORT-1; k >= 0; k--) begin
      i = ptr + PW'(k);
`ifdef IO_SCHED_PRIO0_EN
      if (req[i] && (i != '0)) begin
`else
      if (req[i]) begin
`endif
        valid = 1'b1;
        idx   = i;
      end
    end
`ifdef IO_SCHED_PRIO0_EN
    if (req[0]) begin
      valid = 1'b1;
      idx   = '0;
    end
`endif
  end
endmodule

// File: rtl/io_sched.sv
// Round-robin scheduler sharing the register-file write port between the CPU and four input ports.
// Optional feature: define IO_SCHED_PRIO0_EN for port-0 absolute priority (see rr_pick).
module io_sched
  import io_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int BASE_REG = 12
) (
  input  logic     clk,
  input  logic     reset,
  io_sched_if.slave bus
);
  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt;
  logic [WIDTH-1:0] hold;
  logic             pick_vld;
  logic [PW-1:0]    pick_idx;

  rr_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE:  if (pick_vld) begin
                 gnt   <= pick_idx;
                 state <= CAPT;
               end
        CAPT:  begin
                 hold  <= bus.din[gnt];
                 state <= WRITE;
               end
        WRITE: if (!bus.cpu_we) state <= ACK;
        ACK:   begin
                 ptr   <= gnt + PW'(1);
                 state <= DROP;
               end
        DROP:  if (!bus.req[gnt]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write and ack are pure state decodes so reset kills them without waiting for an edge.
  assign bus.sel  = gnt;
  assign bus.we   = (state == WRITE) && !bus.cpu_we;
  assign bus.wa   = (state == WRITE) ? (4'(BASE_REG) + 4'(gnt)) : 4'd0;
  assign bus.wd   = (state == WRITE) ? hold : '0;
  assign bus.ack  = (state == ACK) ? (NPORT'(1) << gnt) : '0;
  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_io_sched.sv
// Directed self-checking bench for io_sched.
module tb_io_sched;
  import io_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   wr_cnt;
  int   w0;
  int   exp_p;

  io_sched_if #(.WIDTH(8)) bus ();

  io_sched #(.WIDTH(8), .BASE_REG(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.we) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    wr_cnt  = 0;
    reset   = 1'b0;
    bus.req = '0;
    bus.din = '0;
    bus.cpu_we = 1'b0;
    #12;
    chk("rst_sel",  32'(bus.sel), 0);
    chk("rst_we",   32'(bus.we), 0);
    chk("rst_wa",   32'(bus.wa), 0);
    chk("rst_wd",   32'(bus.wd), 0);
    chk("rst_ack",  32'(bus.ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    step();
    reset = 1'b1;

    // Single request on port 2
    bus.req = 4'b0100;
    bus.din[2] = 8'hA5;
    step();
    chk("t1_sel",  32'(bus.sel), 2);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_we0",  32'(bus.we), 0);
    step();
    chk("t1_we",   32'(bus.we), 1);
    chk("t1_wa",   32'(bus.wa), 14);
    chk("t1_wd",   32'(bus.wd), 8'hA5);
    step();
    chk("t1_ack",  32'(bus.ack), 4'b0100);
    chk("t1_we_off", 32'(bus.we), 0);
    step();
    chk("t1_ack_off", 32'(bus.ack), 0);
    chk("t1_drop", 32'(bus.busy), 1);
    step();
    chk("t1_drop_hold", 32'(bus.busy), 1);
    bus.req = '0;
    step();
    chk("t1_idle", 32'(bus.busy), 0);

    // CPU contention: three blocked cycles in WRITE
    bus.req = 4'b0100;
    bus.din[2] = 8'hC3;
    step();
    chk("t2_sel", 32'(bus.sel), 2);
    bus.cpu_we = 1'b1;
    step();
    bus.din[2] = 8'h00;
    #1;
    chk("t2_blk1", 32'(bus.we), 0);
    chk("t2_hold", 32'(bus.wd), 8'hC3);
    step();
    chk("t2_blk2", 32'(bus.we), 0);
    step();
    chk("t2_blk3", 32'(bus.we), 0);
    step();
    bus.cpu_we = 1'b0;
    #1;
    chk("t2_we", 32'(bus.we), 1);
    chk("t2_wa", 32'(bus.wa), 14);
    chk("t2_wd", 32'(bus.wd), 8'hC3);
    step();
    chk("t2_ack", 32'(bus.ack), 4'b0100);
    bus.req = '0;
    step();
    step();
    chk("t2_idle", 32'(bus.busy), 0);

    // Reset asserted while blocked in WRITE
    bus.req = 4'b0001;
    bus.din[0] = 8'h77;
    step();
    bus.cpu_we = 1'b1;
    step();
    chk("t3_busy", 32'(bus.busy), 1);
    chk("t3_wa",   32'(bus.wa), 12);
    w0 = wr_cnt;
    reset = 1'b0;
    #1;
    chk("t3_we",   32'(bus.we), 0);
    chk("t3_ack",  32'(bus.ack), 0);
    chk("t3_rbusy", 32'(bus.busy), 0);
    chk("t3_rwa",  32'(bus.wa), 0);
    bus.req = '0;
    bus.cpu_we = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    chk("t3_idle",   32'(bus.busy), 0);
    chk("t3_nowrite", 32'(wr_cnt), 32'(w0));

    // Fairness: all ports requesting, ptr restarts at 0 after reset
    for (int i = 0; i < 4; i++) bus.din[i] = 8'(8'h10 + i);
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int p;
      p = n % 4;
      step();
      chk("fair_sel", 32'(bus.sel), 32'(p));
      step();
      chk("fair_wa", 32'(bus.wa), 32'(12 + p));
      chk("fair_wd", 32'(bus.wd), 32'(8'h10 + p));
      step();
      chk("fair_ack", 32'(bus.ack), 32'(1 << p));
      bus.req[p] = 1'b0;
      step();
      step();
      chk("fair_idle", 32'(bus.busy), 0);
      bus.req[p] = 1'b1;
    end
    bus.req = '0;

    // Late drop: request falls during CAPT
    bus.req = 4'b0010;
    bus.din[1] = 8'h5E;
    step();
    chk("t5_sel", 32'(bus.sel), 1);
    bus.req = '0;
    step();
    chk("t5_we", 32'(bus.we), 1);
    chk("t5_wa", 32'(bus.wa), 13);
    chk("t5_wd", 32'(bus.wd), 8'h5E);
    step();
    chk("t5_ack", 32'(bus.ack), 4'b0010);
    step();
    chk("t5_drop", 32'(bus.busy), 1);
    step();
    chk("t5_idle", 32'(bus.busy), 0);

    // ptr is now 2; req=1001
`ifdef IO_SCHED_PRIO0_EN
    exp_p = 0;
`else
    exp_p = 3;
`endif
    bus.req = 4'b1001;
    bus.din[0] = 8'h0A;
    bus.din[3] = 8'h3B;
    step();
    chk("t6_sel", 32'(bus.sel), 32'(exp_p));
    step();
    chk("t6_wa", 32'(bus.wa), 32'(12 + exp_p));
    step();
    chk("t6_ack", 32'(bus.ack), 32'(1 << exp_p));
    bus.req = '0;
    step();
    step();
    chk("t6_idle", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/io_sched.md
# io_sched

Round-robin scheduler that shares the register-file write port between the CPU and four 8-bit input ports. It picks one requesting port and drives the input-mux select. It captures that port's byte and writes it into a fixed register during a cycle when the CPU is not writing. It then completes a four-phase req/ack handshake with that port. It sits between the external input ports, the 4-to-1 input mux and the third (write) port of the register file.

## Interface
- `WIDTH`, 8: data width; must match the register file width.
- `BASE_REG`, 12: register index that port 0 writes; port i writes `BASE_REG+i`. Legal range 1..12, so register 0 is never a target.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserted (low) forces the reset state immediately.
- `req` in 4: per-port request; bit i belongs to port i.
- `din` in 4×WIDTH: port data, already routed through the input mux. The block uses only the slice selected by `sel`.
- `cpu_we` in 1: CPU register-file write in this cycle; the CPU always has priority.
- `sel` out 2: input-mux select, equal to the granted port.
- `we` out 1: register-file write enable for this block's write.
- `wa` out 4: write address.
- `wd` out WIDTH: write data.
- `ack` out 4: one-hot acknowledge to the granted port.
- `busy` out 1: high in any state other than IDLE.

## Operation
- State machine: IDLE, CAPT, WRITE, ACK, DROP.
- IDLE:
  - If `req` is non-zero, choose the winner round-robin. Search starts at pointer `ptr` and goes upward, wrapping from 3 to 0.
  - Register the winner in `gnt` and `sel`, then go to CAPT.
  - If `req` is zero, stay in IDLE.
- CAPT: latch `din` (the value selected by `sel`) into `hold`, then go to WRITE.
- WRITE:
  - `wa = BASE_REG+gnt` and `wd = hold` are held stable.
  - `we = !cpu_we` (combinational).
  - If `cpu_we=0`, the write happens on this edge and the FSM goes to ACK.
  - If `cpu_we=1`, the FSM stays in WRITE for as many cycles as needed; there is no timeout.
- ACK:
  - `ack[gnt]=1` for exactly one cycle.
  - `ptr <= gnt+1`, modulo 4.
  - Go to DROP.
- DROP:
  - Wait until `req[gnt]=0`, then go to IDLE.
  - Other ports' requests are ignored until then.
- A port whose `req` falls before its grant simply loses its turn; there is no error.
- A request that falls after the grant does not abort the sequence; the write still completes.
- `busy` is high in CAPT, WRITE, ACK and DROP.

## Timing
- Reset values:
  - State IDLE, `ptr=0`, `gnt=0`, `hold=0`.
  - Outputs `sel=0`, `we=0`, `wa=0`, `wd=0`, `ack=0`, `busy=0`.
- Reset asserted mid-sequence:
  - `we` and `ack` drop immediately.
  - A write pending in WRITE is abandoned and never issued.
- Best-case latency from `req` sampled at edge E:
  - `sel` is valid after E.
  - Data is captured at E+1.
  - The register-file write occurs at E+2.
  - `ack` is high during the cycle after E+2.
  - DROP is entered at E+3.
- The earliest next grant is at the first edge after `req[gnt]` is seen low in DROP, then IDLE.
- Each blocking `cpu_we` cycle adds one cycle of latency.
- Fairness: with all four ports requesting continuously, grants follow 0,1,2,3,0…

## Configuration
- `IO_SCHED_PRIO0_EN` defined:
  - Port 0 has absolute priority in IDLE whenever `req[0]=1`. The round-robin search applies only to ports 1..3.
  - `ptr` still updates on every grant.
- Not defined: pure four-way round-robin as described above.

## Structure
- Shared package `io_pkg` holds:
  - the state encoding (3-bit localparams for IDLE, CAPT, WRITE, ACK, DROP);
  - `NPORT=4`;
  - the port-index width of 2.
- One sub-module, `rr_pick`: combinational 4-way round-robin picker. Inputs are `req` and `ptr`; outputs are `valid` and a 2-bit `idx`. It contains the `IO_SCHED_PRIO0_EN` branch.
- The top level contains the FSM, `hold`, `ptr` and the output decode.

## Test plan
- Single request: `req=0100`, `din2=8'hA5`, `cpu_we=0`.
  - `sel=2` after the first edge.
  - `we=1`, `wa=14`, `wd=A5` for one cycle.
  - `ack=0100` for one cycle.
  - The FSM holds in DROP until `req` falls.
- CPU contention: same stimulus, but `cpu_we=1` for 3 cycles starting in WRITE.
  - `we` stays 0 for those 3 cycles.
  - The write is issued on the 4th cycle with `wd` unchanged.
- Fairness: all `req=1111`, each port lowering its request after its ack.
  - Grant order is 0,1,2,3,0.
  - `wa` sequence is 12,13,14,15,12.
- Reset mid-write: assert `reset` low while in WRITE with `cpu_we=1`.
  - `we` and `ack` go to 0 immediately.
  - After release, the FSM is in IDLE, `ptr=0`, and no write has occurred.
- `IO_SCHED_PRIO0_EN` defined, `ptr=2`, `req=1001`: port 0 is granted (`wa=12`).
  - Without the macro, port 3 is granted (`wa=15`).
- Late drop: `req[1]` is removed while in CAPT.
  - The write still occurs (`wa=13`).
  - `ack[1]` pulses, DROP exits on the next edge, and the FSM returns to IDLE.
